// File: rtl/exec_output_arbiter_if.sv
// Bundle between the execution units, the output arbiter and the memory stage.
// The arbiter takes the slave view; whoever drives the units and the memory stage takes the master view.
interface exec_output_arbiter_if #(
  parameter int NUM_UNITS  = 4,
  parameter int DATA_W     = 64,
  parameter int CMD_W      = 10,
  parameter int FLAG_W     = 4,
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1)
);
  logic                                 flush_i;
  logic [NUM_UNITS-1:0]                 valid_i;
  logic [NUM_UNITS-1:0][DATA_W-1:0]     executeVal_i;
  logic [NUM_UNITS-1:0][CMD_W-1:0]      executeCommands_i;
  logic [NUM_UNITS-1:0][ROBsizeLog-1:0] executeTag_i;
  logic [NUM_UNITS-1:0][FLAG_W-1:0]     executeFlags_i;
  logic [NUM_UNITS-1:0]                 canGo_o;
  logic                                 ready_i;
  logic                                 valid_o;
  logic [DATA_W-1:0]                    dataToMem_o;
  logic [CMD_W-1:0]                     commandsToMem_o;
  logic [ROBsizeLog-1:0]                tagToMem_o;
  logic [FLAG_W-1:0]                    flagsToMem_o;

  modport slave (
    input  flush_i, valid_i, executeVal_i, executeCommands_i, executeTag_i, executeFlags_i,
    input  ready_i,
    output canGo_o, valid_o, dataToMem_o, commandsToMem_o, tagToMem_o, flagsToMem_o
  );

  modport master (
    output flush_i, valid_i, executeVal_i, executeCommands_i, executeTag_i, executeFlags_i,
    output ready_i,
    input  canGo_o, valid_o, dataToMem_o, commandsToMem_o, tagToMem_o, flagsToMem_o
  );
endinterface

// File: rtl/exec_output_arbiter.sv
// Picks one execution-unit result per cycle (fixed priority or round-robin) and holds it in a
// registered output slot that drains to the memory stage over a valid/ready handshake.
module exec_output_arbiter #(
  parameter int NUM_UNITS  = 4,
  parameter int DATA_W     = 64,
  parameter int CMD_W      = 10,
  parameter int FLAG_W     = 4,
  parameter int ROBsize    = 32,
  parameter int ROBsizeLog = $clog2(ROBsize + 1),
  parameter int RR_MODE    = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  exec_output_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NUM_UNITS);

  logic                 slot_free;
  logic                 grant_en;
  logic [NUM_UNITS-1:0] req;
  logic [NUM_UNITS-1:0] pick_src;
  logic [NUM_UNITS-1:0] pick_onehot;
  logic [PTR_W-1:0]     win_idx;

  logic [PTR_W-1:0]      ptr_reg, ptr_next;
  logic                  valid_reg, valid_next;
  logic [DATA_W-1:0]     data_reg, data_next;
  logic [CMD_W-1:0]      cmd_reg, cmd_next;
  logic [ROBsizeLog-1:0] tag_reg, tag_next;
  logic [FLAG_W-1:0]     flags_reg, flags_next;

  assign req       = bus.valid_i;
  // The slot can take a new result if it is empty or is being handed over this very cycle.
  assign slot_free = !valid_reg || bus.ready_i;
  assign grant_en  = !reset_i && !bus.flush_i && slot_free && (req != '0);

  generate
    if (RR_MODE != 0) begin : g_rr
      logic [NUM_UNITS-1:0] at_or_above;
      logic [NUM_UNITS-1:0] upper_req;
      for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_mask
        assign at_or_above[gi] = (PTR_W'(gi) >= ptr_reg);
      end
      // Requests at or above the pointer win first; otherwise the search wraps to index 0.
      assign upper_req = req & at_or_above;
      assign pick_src  = (upper_req != '0) ? upper_req : req;
    end else begin : g_fixed
      assign pick_src = req;
    end
  endgenerate

  assign pick_onehot = pick_src & (~pick_src + NUM_UNITS'(1));
  assign bus.canGo_o = grant_en ? pick_onehot : '0;

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      if (pick_onehot[k]) begin
        win_idx = win_idx | PTR_W'(k);
      end
    end
  end

  // AND-OR payload mux driven by the one-hot pick.
  logic [NUM_UNITS-1:0][DATA_W-1:0]     data_masked;
  logic [NUM_UNITS-1:0][CMD_W-1:0]      cmd_masked;
  logic [NUM_UNITS-1:0][ROBsizeLog-1:0] tag_masked;
  logic [NUM_UNITS-1:0][FLAG_W-1:0]     flags_masked;

  generate
    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_unit
      assign data_masked[gi]  = bus.executeVal_i[gi]      & {DATA_W{pick_onehot[gi]}};
      assign cmd_masked[gi]   = bus.executeCommands_i[gi] & {CMD_W{pick_onehot[gi]}};
      assign tag_masked[gi]   = bus.executeTag_i[gi]      & {ROBsizeLog{pick_onehot[gi]}};
      assign flags_masked[gi] = bus.executeFlags_i[gi]    & {FLAG_W{pick_onehot[gi]}};
    end
  endgenerate

  always_comb begin
    data_next  = data_reg;
    cmd_next   = cmd_reg;
    tag_next   = tag_reg;
    flags_next = flags_reg;
    if (grant_en) begin
      data_next  = '0;
      cmd_next   = '0;
      tag_next   = '0;
      flags_next = '0;
      for (int k = 0; k < NUM_UNITS; k++) begin
        data_next  = data_next  | data_masked[k];
        cmd_next   = cmd_next   | cmd_masked[k];
        tag_next   = tag_next   | tag_masked[k];
        flags_next = flags_next | flags_masked[k];
      end
    end
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (grant_en) begin
      ptr_next = (win_idx == PTR_W'(NUM_UNITS - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  // A flush squashes the slot even while stalled; a drain without refill just empties it.
  always_comb begin
    valid_next = valid_reg;
    if (bus.flush_i) begin
      valid_next = 1'b0;
    end else if (grant_en) begin
      valid_next = 1'b1;
    end else if (bus.ready_i) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_reg   <= '0;
      valid_reg <= 1'b0;
      data_reg  <= '0;
      cmd_reg   <= '0;
      tag_reg   <= '0;
      flags_reg <= '0;
    end else begin
      ptr_reg   <= ptr_next;
      valid_reg <= valid_next;
      data_reg  <= data_next;
      cmd_reg   <= cmd_next;
      tag_reg   <= tag_next;
      flags_reg <= flags_next;
    end
  end

  assign bus.valid_o         = valid_reg;
  assign bus.dataToMem_o     = data_reg;
  assign bus.commandsToMem_o = cmd_reg;
  assign bus.tagToMem_o      = tag_reg;
  assign bus.flagsToMem_o    = flags_reg;
endmodule

// File: tb/tb_exec_output_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with the same style of traffic and checks both
// against a queue-based reference model; index 0 is the fixed-priority instance, index 1 round-robin.
module tb_exec_output_arbiter;
  localparam int N    = 4;
  localparam int DW   = 64;
  localparam int CW   = 10;
  localparam int FW   = 4;
  localparam int ROBS = 32;
  localparam int TW   = $clog2(ROBS + 1);

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic [TW-1:0] t;
    logic [FW-1:0] f;
  } res_t;

  logic clk = 1'b0;
  logic reset, flush, ready;
  bit   running = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]         vin   [2];
  logic [N-1:0][DW-1:0] dat_v [2];
  logic [N-1:0][CW-1:0] cmd_v [2];
  logic [N-1:0][TW-1:0] tag_v [2];
  logic [N-1:0][FW-1:0] flg_v [2];

  wire [N-1:0]  cango [2];
  wire          vout  [2];
  wire [DW-1:0] dout  [2];
  wire [CW-1:0] cout  [2];
  wire [TW-1:0] tout  [2];
  wire [FW-1:0] fout  [2];

  exec_output_arbiter_if #(.NUM_UNITS(N), .DATA_W(DW), .CMD_W(CW), .FLAG_W(FW),
                           .ROBsize(ROBS), .ROBsizeLog(TW)) bus [2] ();

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign bus[gi].flush_i           = flush;
    assign bus[gi].ready_i           = ready;
    assign bus[gi].valid_i           = vin[gi];
    assign bus[gi].executeVal_i      = dat_v[gi];
    assign bus[gi].executeCommands_i = cmd_v[gi];
    assign bus[gi].executeTag_i      = tag_v[gi];
    assign bus[gi].executeFlags_i    = flg_v[gi];
    assign cango[gi] = bus[gi].canGo_o;
    assign vout[gi]  = bus[gi].valid_o;
    assign dout[gi]  = bus[gi].dataToMem_o;
    assign cout[gi]  = bus[gi].commandsToMem_o;
    assign tout[gi]  = bus[gi].tagToMem_o;
    assign fout[gi]  = bus[gi].flagsToMem_o;

    exec_output_arbiter #(.NUM_UNITS(N), .DATA_W(DW), .CMD_W(CW), .FLAG_W(FW),
                          .ROBsize(ROBS), .ROBsizeLog(TW), .RR_MODE(gi)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (bus[gi])
    );
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string name, int d, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, d, act, exp);
  endtask

  // Reference model state: slot occupancy, round-robin pointer and one queue of expected results.
  bit       mvalid [2];
  int       mptr   [2];
  logic [N-1:0] granted_last [2];
  bit       rst_prev = 1'b1;
  res_t     sbq [2][$];

  function automatic logic [N-1:0] exp_grant(int d);
    logic [N-1:0] g;
    int start;
    bit found;
    g = '0;
    found = 1'b0;
    if (reset || flush || (mvalid[d] && !ready) || vin[d] == '0) return g;
    start = (d == 1) ? mptr[d] : 0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (start + i) % N;
      if (!found && vin[d][k]) begin
        g[k] = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  logic [N-1:0] m_eg;
  int           m_w;
  res_t         m_r;

  always @(negedge clk) begin
    if (running) begin
      for (int d = 0; d < 2; d++) begin
        m_eg = exp_grant(d);
        chk("canGo", d, 64'(cango[d]), 64'(m_eg));
        chk("valid_o", d, 64'(vout[d]), 64'(mvalid[d]));
        if (reset && rst_prev) chk("reset_data", d, dout[d], 64'd0);
        granted_last[d] = m_eg;
        if (reset) begin
          mvalid[d] = 1'b0;
          mptr[d]   = 0;
          sbq[d].delete();
        end else if (m_eg != '0) begin
          m_w = 0;
          for (int k = 0; k < N; k++) if (m_eg[k]) m_w = k;
          m_r.d = dat_v[d][m_w];
          m_r.c = cmd_v[d][m_w];
          m_r.t = tag_v[d][m_w];
          m_r.f = flg_v[d][m_w];
          sbq[d].push_back(m_r);
          mvalid[d] = 1'b1;
          if (d == 1) mptr[d] = (m_w + 1) % N;
        end else if (flush || ready) begin
          mvalid[d] = 1'b0;
        end
      end
      rst_prev = reset;
    end
  end

  // Monitor: whenever the slot is occupied its payload must equal the oldest expected result.
  res_t mon_r;
  always @(negedge clk) begin
    if (running && !reset) begin
      for (int d = 0; d < 2; d++) begin
        if (vout[d]) begin
          if (sbq[d].size() == 0) begin
            chk("unexpected_out", d, 64'd1, 64'd0);
          end else begin
            mon_r = sbq[d][0];
            chk("data", d, dout[d], mon_r.d);
            chk("cmd", d, 64'(cout[d]), 64'(mon_r.c));
            chk("tag", d, 64'(tout[d]), 64'(mon_r.t));
            chk("flags", d, 64'(fout[d]), 64'(mon_r.f));
            if (ready) $display("dut%0d xfer tag=%0d cmd=%0h data=%h", d, tout[d], cout[d], dout[d]);
            if (ready || flush) void'(sbq[d].pop_front());
          end
        end
      end
    end
  end

  task automatic new_payload(int d, int k);
    dat_v[d][k] = {$urandom(), $urandom()};
    cmd_v[d][k] = CW'($urandom());
    tag_v[d][k] = TW'($urandom());
    flg_v[d][k] = FW'($urandom());
  endtask

  // A unit keeps its payload until granted; only fresh requests get new data.
  task automatic set_valid(logic [N-1:0] v);
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N; k++) begin
        if (v[k] && (!vin[d][k] || granted_last[d][k])) new_payload(d, k);
        vin[d][k] = v[k];
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mvalid[d] = 1'b0;
      mptr[d] = 0;
      granted_last[d] = '0;
      vin[d] = '1;
      for (int k = 0; k < N; k++) new_payload(d, k);
    end
    // Reset held for two checked cycles with every unit requesting.
    step();
    running = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Non-adjacent requests: unit 1 must win in both modes from a fresh pointer.
    ready = 1'b1;
    set_valid(4'b1010); step();
    set_valid(4'b0000); step();

    // All units requesting for eight cycles from a freshly reset pointer.
    reset = 1'b1; step(); step(); reset = 1'b0;
    repeat (8) begin set_valid(4'b1111); step(); end
    set_valid(4'b0000); step();

    // Move the pointer to the last unit, then check skip and wrap.
    set_valid(4'b0100); step();
    set_valid(4'b0101); step();
    set_valid(4'b0101); step();
    set_valid(4'b0000); step();

    // Backpressure on a result carrying tag 5.
    set_valid(4'b0001);
    tag_v[0][0] = TW'(5);
    tag_v[1][0] = TW'(5);
    step();
    ready = 1'b0;
    repeat (3) begin set_valid(4'b0001); step(); end
    ready = 1'b1;
    set_valid(4'b0001); step();
    set_valid(4'b0000); step();

    // Flush while the slot is stalled, then resume with everyone requesting.
    set_valid(4'b0001); step();
    ready = 1'b0; flush = 1'b1;
    set_valid(4'b0100); step();
    flush = 1'b0; ready = 1'b1;
    set_valid(4'b1111); step();
    set_valid(4'b0000); step();

    // Randomised traffic with stalls, flushes and occasional resets.
    repeat (3000) begin
      reset = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 19) == 0);
      ready = ($urandom_range(0, 9) < 7);
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < N; k++) begin
          if (granted_last[d][k] || !vin[d][k]) begin
            vin[d][k] = ($urandom_range(0, 9) < 5);
            if (vin[d][k]) new_payload(d, k);
          end
        end
      end
      step();
    end

    reset = 1'b0; flush = 1'b0; ready = 1'b1;
    set_valid(4'b0000);
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
